trap_ctrl: RTL and testbench



---
 rtl/trap_pkg.sv | 27 ++
 rtl/irq_sync.sv | 27 ++
 rtl/trap_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_trap_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } trap_state_t;

    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;

    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_U = 2'b00;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer bank for asynchronous interrupt request levels.
module irq_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: arbitrates exceptions, interrupts and MRET, sequences the
// CSR commit pulses, redirects fetch and tracks the privilege level.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [DATA_WIDTH-1:0] ex_cause,
    input  logic [DATA_WIDTH-1:0] ex_pc,
    input  logic [DATA_WIDTH-1:0] ex_tval,
    input  logic                  mret_valid,
    input  logic [DATA_WIDTH-1:0] int_pc,
    input  logic                  boundary_valid,
    input  logic                  irq_sw,
    input  logic                  irq_timer,
    input  logic                  irq_ext,
    input  logic [DATA_WIDTH-1:0] mstatus_in,
    input  logic [DATA_WIDTH-1:0] mie_in,
    input  logic [DATA_WIDTH-1:0] mtvec_in,
    input  logic [DATA_WIDTH-1:0] mepc_in,
    input  logic                  mem_stall,
    output logic                  exception_commit,
    output logic                  mret_commit,
    output logic [DATA_WIDTH-1:0] exception_pc,
    output logic [DATA_WIDTH-1:0] exception_cause,
    output logic [DATA_WIDTH-1:0] exception_tval,
    output logic [DATA_WIDTH-1:0] mip_out,
    output logic [1:0]            priv_level,
    output logic                  stall_req,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

    trap_state_t           state_r, next_state_s;
    logic [1:0]            holdoff_r;
    logic [DATA_WIDTH-1:0] cause_r, pc_r, tval_r;
    logic                  is_mret_r;
    logic                  exc_commit_r, mret_commit_r, redirect_r, busy_r;
    logic [1:0]            priv_r;

    logic [2:0]            irq_raw_s, irq_sync_s;
    logic [DATA_WIDTH-1:0] mip_s, pend_s, int_cause_s;
    logic                  int_take_s;
    logic                  event_s, ev_mret_s, kind_next_s;
    logic [DATA_WIDTH-1:0] ev_cause_s, ev_pc_s, ev_tval_s;
    logic [DATA_WIDTH-1:0] base_s, redirect_pc_s;
    logic                  unused_ok_s;

    assign irq_raw_s = {irq_ext, irq_timer, irq_sw};

    irq_sync #(.WIDTH(3)) u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (irq_raw_s),
        .q     (irq_sync_s)
    );

    // Place synchronized levels at their mip bit positions.
    always_comb begin
        mip_s           = {DATA_WIDTH{1'b0}};
        mip_s[MIP_MSIP] = irq_sync_s[0];
        mip_s[MIP_MTIP] = irq_sync_s[1];
        mip_s[MIP_MEIP] = irq_sync_s[2];
    end

    assign pend_s     = mie_in & mip_s;
    assign int_take_s = boundary_valid & mstatus_in[MSTATUS_MIE] & (|pend_s) & (holdoff_r == 2'd0);

    // Interrupt sub-priority: external, then software, then timer.
    always_comb begin
        int_cause_s = DATA_WIDTH'(CAUSE_MTI);
        if (pend_s[MIP_MEIP]) begin
            int_cause_s = DATA_WIDTH'(CAUSE_MEI);
        end else if (pend_s[MIP_MSIP]) begin
            int_cause_s = DATA_WIDTH'(CAUSE_MSI);
        end else begin
            int_cause_s = DATA_WIDTH'(CAUSE_MTI);
        end
    end

    // Event selection and next-state decode.
    always_comb begin
        next_state_s = state_r;
        event_s      = 1'b0;
        ev_mret_s    = 1'b0;
        ev_cause_s   = {DATA_WIDTH{1'b0}};
        ev_pc_s      = {DATA_WIDTH{1'b0}};
        ev_tval_s    = {DATA_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (ex_valid) begin
                    event_s    = 1'b1;
                    ev_cause_s = ex_cause;
                    ev_pc_s    = ex_pc;
                    ev_tval_s  = ex_tval;
                end else if (int_take_s) begin
                    event_s    = 1'b1;
                    ev_cause_s = int_cause_s;
                    ev_pc_s    = int_pc;
                end else if (mret_valid) begin
                    event_s   = 1'b1;
                    ev_mret_s = 1'b1;
                end else begin
                    event_s = 1'b0;
                end
                if (event_s) begin
                    next_state_s = mem_stall ? WAIT : COMMIT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT:     next_state_s = mem_stall ? WAIT : COMMIT;
            COMMIT:   next_state_s = REDIRECT;
            REDIRECT: next_state_s = IDLE;
            default:  next_state_s = IDLE;
        endcase
        kind_next_s = event_s ? ev_mret_s : is_mret_r;
    end

    // State, captured trap data, holdoff and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            holdoff_r     <= 2'd0;
            cause_r       <= {DATA_WIDTH{1'b0}};
            pc_r          <= {DATA_WIDTH{1'b0}};
            tval_r        <= {DATA_WIDTH{1'b0}};
            is_mret_r     <= 1'b0;
            exc_commit_r  <= 1'b0;
            mret_commit_r <= 1'b0;
            redirect_r    <= 1'b0;
            busy_r        <= 1'b0;
            priv_r        <= PRIV_M;
        end else begin
            state_r <= next_state_s;
            if (event_s) begin
                cause_r   <= ev_cause_s;
                pc_r      <= ev_pc_s;
                tval_r    <= ev_tval_s;
                is_mret_r <= ev_mret_s;
            end
            // Holdoff keeps interrupts off until the CSR file's mstatus write is visible.
            if (state_r == REDIRECT) begin
                holdoff_r <= 2'd2;
            end else if ((state_r == IDLE) && (holdoff_r != 2'd0)) begin
                holdoff_r <= holdoff_r - 2'd1;
            end
            exc_commit_r  <= (next_state_s == COMMIT) && !kind_next_s;
            mret_commit_r <= (next_state_s == COMMIT) && kind_next_s;
            redirect_r    <= (next_state_s == REDIRECT);
            busy_r        <= (next_state_s != IDLE);
            if (next_state_s == COMMIT) begin
                priv_r <= kind_next_s ? mstatus_in[MSTATUS_MPP_HI:MSTATUS_MPP_LO] : PRIV_M;
            end
        end
    end

    assign base_s = {mtvec_in[DATA_WIDTH-1:2], 2'b00};

    // Redirect target: return address, vectored handler slot, or handler base.
    always_comb begin
        redirect_pc_s = base_s;
        if (is_mret_r) begin
            redirect_pc_s = mepc_in;
        end else if ((mtvec_in[1:0] == 2'b01) && cause_r[DATA_WIDTH-1]) begin
            redirect_pc_s = base_s + {cause_r[DATA_WIDTH-3:0], 2'b00};
        end else begin
            redirect_pc_s = base_s;
        end
    end

    assign exception_commit = exc_commit_r;
    assign mret_commit      = mret_commit_r;
    assign exception_pc     = pc_r;
    assign exception_cause  = cause_r;
    assign exception_tval   = tval_r;
    assign mip_out          = mip_s;
    assign priv_level       = priv_r;
    assign stall_req        = busy_r;
    assign flush            = busy_r;
    assign redirect_valid   = redirect_r;
    assign redirect_pc      = redirect_pc_s;

    assign unused_ok_s = ^{mstatus_in, PRIV_U, MSTATUS_MPIE};

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_valid, mret_valid, boundary_valid, mem_stall;
    logic          irq_sw, irq_timer, irq_ext;
    logic [DW-1:0] ex_cause, ex_pc, ex_tval, int_pc;
    logic [DW-1:0] mstatus_in, mie_in, mtvec_in, mepc_in;
    logic          exception_commit, mret_commit, stall_req, flush, redirect_valid;
    logic [DW-1:0] exception_pc, exception_cause, exception_tval, mip_out, redirect_pc;
    logic [1:0]    priv_level;

    int checks   = 0;
    int failures = 0;

    trap_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_cause(ex_cause), .ex_pc(ex_pc),
        .ex_tval(ex_tval), .mret_valid(mret_valid), .int_pc(int_pc), .boundary_valid(boundary_valid),
        .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext), .mstatus_in(mstatus_in),
        .mie_in(mie_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in), .mem_stall(mem_stall),
        .exception_commit(exception_commit), .mret_commit(mret_commit), .exception_pc(exception_pc),
        .exception_cause(exception_cause), .exception_tval(exception_tval), .mip_out(mip_out),
        .priv_level(priv_level), .stall_req(stall_req), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_valid = 1'b0; mret_valid = 1'b0; boundary_valid = 1'b0; mem_stall = 1'b0;
        irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
        ex_cause = 32'h0; ex_pc = 32'h0; ex_tval = 32'h0; int_pc = 32'h0;
        mstatus_in = 32'h0; mie_in = 32'h0; mtvec_in = 32'h0; mepc_in = 32'h0;
        repeat (2) tick();
        checks++; if ({exception_commit, mret_commit, redirect_valid, stall_req, flush} !== 5'b0) begin $display("FAIL reset_pulses got=%b exp=00000", {exception_commit, mret_commit, redirect_valid, stall_req, flush}); failures++; end
        checks++; if (priv_level !== 2'b11) begin $display("FAIL reset_priv got=%0d exp=3", priv_level); failures++; end
        checks++; if ({exception_pc, exception_cause, exception_tval, mip_out} !== 128'h0) begin $display("FAIL reset_data got=%h exp=0", {exception_pc, exception_cause, exception_tval, mip_out}); failures++; end
        checks++; if (redirect_pc !== 32'h0) begin $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); failures++; end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mret();
        mepc_in = 32'h80; mstatus_in = 32'h0; mret_valid = 1'b1;
        tick();
        mret_valid = 1'b0;
        checks++; if ({mret_commit, exception_commit} !== 2'b10) begin $display("FAIL mret_commit got=%b exp=10", {mret_commit, exception_commit}); failures++; end
        checks++; if (priv_level !== 2'b00) begin $display("FAIL mret_priv got=%0d exp=0", priv_level); failures++; end
        tick();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin $display("FAIL mret_redirect got=%b/%h exp=1/00000080", redirect_valid, redirect_pc); failures++; end
        tick();
        checks++; if ({redirect_valid, stall_req, mret_commit} !== 3'b0) begin $display("FAIL mret_idle got=%b exp=000", {redirect_valid, stall_req, mret_commit}); failures++; end
    endtask

    task automatic test_exception();
        repeat (3) tick();
        mtvec_in = 32'h200; ex_cause = 32'h2; ex_pc = 32'h100; ex_tval = 32'hDEAD; ex_valid = 1'b1;
        checks++; if (stall_req !== 1'b0) begin $display("FAIL exc_detect_stall got=%b exp=0", stall_req); failures++; end
        tick();
        ex_valid = 1'b0;
        checks++; if ({exception_commit, mret_commit, stall_req, flush} !== 4'b1011) begin $display("FAIL exc_commit got=%b exp=1011", {exception_commit, mret_commit, stall_req, flush}); failures++; end
        checks++; if ({exception_cause, exception_pc, exception_tval} !== {32'h2, 32'h100, 32'hDEAD}) begin $display("FAIL exc_data got=%h exp=%h", {exception_cause, exception_pc, exception_tval}, {32'h2, 32'h100, 32'hDEAD}); failures++; end
        checks++; if (priv_level !== 2'b11) begin $display("FAIL exc_priv got=%0d exp=3", priv_level); failures++; end
        tick();
        checks++; if ({redirect_valid, exception_commit} !== 2'b10 || redirect_pc !== 32'h200) begin $display("FAIL exc_redirect got=%b/%h exp=10/00000200", {redirect_valid, exception_commit}, redirect_pc); failures++; end
        tick();
        checks++; if ({redirect_valid, stall_req, flush} !== 3'b0) begin $display("FAIL exc_idle got=%b exp=000", {redirect_valid, stall_req, flush}); failures++; end
    endtask

    task automatic test_vectored_irq();
        repeat (3) tick();
        mtvec_in = 32'h201; mstatus_in = 32'h8; mie_in = 32'h800; boundary_valid = 1'b1;
        int_pc = 32'h40; irq_ext = 1'b1;
        tick();
        checks++; if (mip_out !== 32'h0 || exception_commit !== 1'b0) begin $display("FAIL irq_sync1 got=%h/%b exp=0/0", mip_out, exception_commit); failures++; end
        tick();
        checks++; if (mip_out !== 32'h800 || exception_commit !== 1'b0) begin $display("FAIL irq_sync2 got=%h/%b exp=00000800/0", mip_out, exception_commit); failures++; end
        tick();
        boundary_valid = 1'b0; irq_ext = 1'b0;
        checks++; if (exception_commit !== 1'b1) begin $display("FAIL irq_commit got=%b exp=1", exception_commit); failures++; end
        checks++; if ({exception_cause, exception_pc, exception_tval} !== {32'h8000000B, 32'h40, 32'h0}) begin $display("FAIL irq_data got=%h exp=%h", {exception_cause, exception_pc, exception_tval}, {32'h8000000B, 32'h40, 32'h0}); failures++; end
        tick();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h22C) begin $display("FAIL irq_redirect got=%b/%h exp=1/0000022c", redirect_valid, redirect_pc); failures++; end
        tick();
        mie_in = 32'h0; mstatus_in = 32'h0; mtvec_in = 32'h200;
        repeat (3) tick();
    endtask

    task automatic test_stall();
        ex_cause = 32'h4; ex_pc = 32'h300; ex_tval = 32'h11; ex_valid = 1'b1; mem_stall = 1'b1;
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_stall = 1'b0;
            checks++; if ({exception_commit, stall_req, flush} !== 3'b011) begin $display("FAIL stall_wait%0d got=%b exp=011", i, {exception_commit, stall_req, flush}); failures++; end
            tick();
        end
        checks++; if ({exception_commit, stall_req} !== 2'b11 || exception_pc !== 32'h300) begin $display("FAIL stall_commit got=%b/%h exp=11/00000300", {exception_commit, stall_req}, exception_pc); failures++; end
        tick();
        checks++; if ({redirect_valid, stall_req, flush} !== 3'b111) begin $display("FAIL stall_redirect got=%b exp=111", {redirect_valid, stall_req, flush}); failures++; end
        tick();
        checks++; if ({stall_req, flush} !== 2'b00) begin $display("FAIL stall_release got=%b exp=00", {stall_req, flush}); failures++; end
    endtask

    task automatic test_priority_holdoff();
        repeat (2) tick();
        mtvec_in = 32'h200; mstatus_in = 32'h8; mie_in = 32'h80; irq_timer = 1'b1; int_pc = 32'h500;
        repeat (3) tick();
        checks++; if (mip_out !== 32'h80) begin $display("FAIL prio_mip got=%h exp=00000080", mip_out); failures++; end
        boundary_valid = 1'b1; ex_valid = 1'b1; ex_cause = 32'h5; ex_pc = 32'h600; mret_valid = 1'b1; mepc_in = 32'h900;
        tick();
        ex_valid = 1'b0; mret_valid = 1'b0;
        checks++; if ({exception_commit, mret_commit} !== 2'b10 || exception_cause !== 32'h5) begin $display("FAIL prio_winner got=%b/%h exp=10/00000005", {exception_commit, mret_commit}, exception_cause); failures++; end
        tick();
        checks++; if (redirect_pc !== 32'h200) begin $display("FAIL prio_redirect got=%h exp=00000200", redirect_pc); failures++; end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({exception_commit, mret_commit, stall_req} !== 3'b0) begin $display("FAIL holdoff%0d got=%b exp=000", i, {exception_commit, mret_commit, stall_req}); failures++; end
        end
        tick();
        boundary_valid = 1'b0; irq_timer = 1'b0;
        checks++; if (exception_commit !== 1'b1 || exception_cause !== 32'h80000007 || exception_pc !== 32'h500) begin $display("FAIL holdoff_take got=%b/%h/%h exp=1/80000007/00000500", exception_commit, exception_cause, exception_pc); failures++; end
        mie_in = 32'h0; mstatus_in = 32'h0;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        mepc_in = 32'h80; mstatus_in = 32'h0; mret_valid = 1'b1;
        tick();
        mret_valid = 1'b0;
        repeat (2) tick();
        checks++; if (priv_level !== 2'b00) begin $display("FAIL rstmid_pre_priv got=%0d exp=0", priv_level); failures++; end
        ex_valid = 1'b1; ex_pc = 32'h700; ex_cause = 32'h6; mem_stall = 1'b1;
        tick();
        ex_valid = 1'b0;
        checks++; if ({stall_req, exception_commit} !== 2'b10) begin $display("FAIL rstmid_wait got=%b exp=10", {stall_req, exception_commit}); failures++; end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({stall_req, flush, redirect_valid, exception_commit, mret_commit} !== 5'b0 || priv_level !== 2'b11) begin $display("FAIL rstmid_outputs got=%b/%0d exp=00000/3", {stall_req, flush, redirect_valid, exception_commit, mret_commit}, priv_level); failures++; end
        checks++; if ({exception_pc, exception_cause, exception_tval} !== 96'h0) begin $display("FAIL rstmid_data got=%h exp=0", {exception_pc, exception_cause, exception_tval}); failures++; end
        #3 rst_n = 1'b1; mem_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({exception_commit, mret_commit, redirect_valid, stall_req} !== 4'b0) begin $display("FAIL rstmid_post%0d got=%b exp=0000", i, {exception_commit, mret_commit, redirect_valid, stall_req}); failures++; end
        end
    endtask

    initial begin
        test_reset();
        test_mret();
        test_exception();
        test_vectored_irq();
        test_stall();
        test_priority_holdoff();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
